cpu_perf_monitor: RTL and testbench
===================================

Name: cpu_perf_monitor

Overview:
- On-chip performance/trace monitor that sits directly downstream of the pipelined CPU and consumes its per-cycle status: stall, branch, flush, retire, PC.
- Counts run cycles, stalls, flushes and retired instructions, and tracks the last PC.
- Asserts a halt request when a programmed cycle limit is reached.
- Exposes counters through a one-request/one-ack readout port for the bench or a debug host.

Parameters:
CNT_W, 32, width of every counter and of limit_i/rd_data_o
PC_W, 32, width of pc_i

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  CPU start; counting enabled only while high
limit_i  in  CNT_W  cycle limit, latched on IDLE->RUN; 0 = unlimited
stall_i  in  1  hazard-unit stall
branch_i  in  1  control-unit branch; a stall with branch high is not counted
flush_i  in  1  IF/ID flush
retire_i  in  1  instruction retiring in WB this cycle
pc_i  in  PC_W  current PC
clear_i  in  1  synchronous clear of counters and FSM
rd_req_i  in  1  readout request
rd_sel_i  in  3  0 cycle, 1 stall, 2 flush, 3 retire, 4 last_pc (zero-extended/truncated to CNT_W), 5 {state,limit_hit} zero-extended, 6-7 read 0
rd_ack_o  out  1  one-cycle readout acknowledge
rd_data_o  out  CNT_W  readout data, valid while rd_ack_o=1, held until next ack
state_o  out  2  00 IDLE, 01 RUN, 10 DONE
halt_o  out  1  level; high in DONE

Behaviour:
- Reset (rst_i=0, async): state IDLE; all counters, last_pc and limit = 0; rd_ack_o=0, rd_data_o=0, halt_o=0, state_o=00. Reset mid-RUN aborts immediately, with no further counting.
- Priority each edge: clear_i > FSM transition > counting.
- clear_i=1, any state: all counters and last_pc zeroed, next state IDLE, halt_o=0. clear_i with start_i in IDLE stays IDLE.
- IDLE: no counting. start_i=1 -> RUN and latch limit_i. No counting on the transition edge.
- RUN with start_i=1, each edge:
  - cycle_cnt += 1.
  - stall_cnt += 1 if stall_i & ~branch_i.
  - flush_cnt += 1 if flush_i.
  - retire_cnt += 1 if retire_i.
  - last_pc <= pc_i.
- RUN with start_i=0: all counters hold (pause); stays in RUN.
- Limit:
  - If limit != 0 and the counting edge makes cycle_cnt == limit, go to DONE on that same edge. halt_o=1 from the next cycle.
  - Events on the limit cycle are counted.
- DONE: counters frozen; only clear_i or reset leaves.
- Counters saturate at all-ones and never wrap. cycle_cnt saturation with limit=0 stays in RUN.
- Readout handshake:
  - On an edge with rd_req_i=1 and rd_ack_o=0: rd_data_o <= selected value as it stood before that edge's update (pre-increment), and rd_ack_o <= 1.
  - Next edge: rd_ack_o <= 0, unconditionally.
  - A held rd_req_i therefore produces an ack every other cycle.
  - Requests while rd_ack_o=1 are ignored.
  - Readout is legal in every state and never disturbs counting.
  - clear_i in the same cycle as a request: the ack carries pre-clear data.
- state_o and halt_o are registered outputs.

Test Plan:
- limit_i=64, start_i=1 held, retire_i=1 every cycle -> DONE after 64 counting edges; cycle=64, retire=64, halt_o=1; counters frozen for 10 further cycles.
- 5 cycles stall_i=1 with branch_i=1 in cycles 2-3, flush_i=1 in cycle 3 -> stall=3, flush=1 on readout sel=1 and sel=2.
- CNT_W=4, limit=0, 20 run cycles with stall_i=1 -> cycle=15, stall=15, state still RUN.
- start_i dropped for 7 cycles mid-run, then restored, total 20 high cycles with limit=0 -> cycle=20. clear_i then -> IDLE, all reads 0.
- rst_i pulsed low mid-RUN at cycle 10 -> outputs 0 immediately without a clock edge; IDLE; a new start_i relatches limit.
- rd_req_i held high 4 cycles with sel=0 during RUN -> two ack pulses 2 cycles apart, data = cycle_cnt pre-edge (e.g. 5 then 7). pc_i=0x40 then sel=4 -> rd_data_o=0x40.

Source files
------------

// File: rtl/cpu_perf_monitor.sv
// Performance monitor for a pipelined CPU: counts cycles, stalls, flushes and retirements,
// raises a halt request at a programmed cycle limit, and serves counters over a req/ack port.
module cpu_perf_monitor #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             clear_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [1:0]       state_o,
    output logic             halt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   cycle_q, stall_q, flush_q, retire_q;
    logic [PC_W-1:0]    last_pc_q;
    logic               limit_hit_q;
    logic               halt_q;
    logic               rd_ack_q;
    logic [CNT_W-1:0]   rd_data_q;

    logic [CNT_W-1:0]   cycle_d, stall_d, flush_d, retire_d;
    logic               limit_reached;
    logic [CNT_W-1:0]   rd_mux;

    // Saturating increment: an all-ones counter stays all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (!en || (&v))
            return v;
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        cycle_d       = sat_inc(cycle_q, 1'b1);
        stall_d       = sat_inc(stall_q, stall_i & ~branch_i);
        flush_d       = sat_inc(flush_q, flush_i);
        retire_d      = sat_inc(retire_q, retire_i);
        limit_reached = (limit_q != '0) && (cycle_d == limit_q);
    end

    // Readout sees register values as they stand before this edge's update.
    always_comb begin
        rd_mux = '0;
        case (rd_sel_i)
            3'd0:    rd_mux = cycle_q;
            3'd1:    rd_mux = stall_q;
            3'd2:    rd_mux = flush_q;
            3'd3:    rd_mux = retire_q;
            3'd4:    rd_mux = CNT_W'(last_pc_q);
            3'd5:    rd_mux = CNT_W'({state_q, limit_hit_q});
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            cycle_q     <= '0;
            stall_q     <= '0;
            flush_q     <= '0;
            retire_q    <= '0;
            last_pc_q   <= '0;
            limit_hit_q <= 1'b0;
            halt_q      <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (rd_ack_q) begin
                rd_ack_q <= 1'b0;
            end else if (rd_req_i) begin
                rd_ack_q  <= 1'b1;
                rd_data_q <= rd_mux;
            end

            if (clear_i) begin
                state_q     <= IDLE;
                cycle_q     <= '0;
                stall_q     <= '0;
                flush_q     <= '0;
                retire_q    <= '0;
                last_pc_q   <= '0;
                limit_hit_q <= 1'b0;
                halt_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= RUN;
                            limit_q <= limit_i;
                        end
                    end
                    RUN: begin
                        // start_i low pauses without leaving RUN.
                        if (start_i) begin
                            cycle_q   <= cycle_d;
                            stall_q   <= stall_d;
                            flush_q   <= flush_d;
                            retire_q  <= retire_d;
                            last_pc_q <= pc_i;
                            if (limit_reached) begin
                                state_q     <= DONE;
                                limit_hit_q <= 1'b1;
                                halt_q      <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_o   = state_q;
    assign halt_o    = halt_q;
    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Bench for cpu_perf_monitor: directed scenarios plus a randomized phase, all checked
// against a cycle-level behavioural model of the counters, FSM and readout port.
module tb_cpu_perf_monitor;

    localparam longint MAXV = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0, stall_i = 1'b0, branch_i = 1'b0, flush_i = 1'b0;
    logic        retire_i = 1'b0, clear_i = 1'b0, rd_req_i = 1'b0;
    logic [31:0] limit_i = '0, pc_i = '0;
    logic [2:0]  rd_sel_i = '0;
    logic        rd_ack_o, halt_o;
    logic [31:0] rd_data_o;
    logic [1:0]  state_o;

    logic        s4_start = 1'b0, s4_stall = 1'b0, s4_rd_req = 1'b0;
    logic [2:0]  s4_rd_sel = '0;
    logic        s4_ack, s4_halt;
    logic [3:0]  s4_data;
    logic [1:0]  s4_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_perf_monitor #(.CNT_W(32), .PC_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .limit_i(limit_i),
        .stall_i(stall_i), .branch_i(branch_i), .flush_i(flush_i), .retire_i(retire_i),
        .pc_i(pc_i), .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
        .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o), .state_o(state_o), .halt_o(halt_o)
    );

    cpu_perf_monitor #(.CNT_W(4), .PC_W(32)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(s4_start), .limit_i(4'd0),
        .stall_i(s4_stall), .branch_i(1'b0), .flush_i(1'b0), .retire_i(1'b0),
        .pc_i(32'd0), .clear_i(1'b0), .rd_req_i(s4_rd_req), .rd_sel_i(s4_rd_sel),
        .rd_ack_o(s4_ack), .rd_data_o(s4_data), .state_o(s4_state), .halt_o(s4_halt)
    );

    // Behavioural model: state 0 idle, 1 run, 2 done.
    int     m_state;
    longint m_limit, m_cyc, m_stl, m_fl, m_ret, m_pc, m_data;
    bit     m_hit, m_ack, m_halt;

    task automatic model_reset();
        m_state = 0; m_limit = 0; m_cyc = 0; m_stl = 0; m_fl = 0; m_ret = 0;
        m_pc = 0; m_data = 0; m_hit = 0; m_ack = 0; m_halt = 0;
    endtask

    function automatic longint sat1(longint v);
        return (v < MAXV) ? v + 1 : v;
    endfunction

    function automatic longint sel_val(int s);
        case (s)
            0: return m_cyc;
            1: return m_stl;
            2: return m_fl;
            3: return m_ret;
            4: return m_pc;
            5: return longint'(m_state) * 2 + longint'(m_hit);
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        if (!m_ack && rd_req_i) begin
            m_data = sel_val(int'(rd_sel_i));
            m_ack  = 1;
        end else begin
            m_ack = 0;
        end
        if (clear_i) begin
            m_state = 0; m_cyc = 0; m_stl = 0; m_fl = 0; m_ret = 0; m_pc = 0; m_hit = 0;
        end else if (m_state == 0) begin
            if (start_i) begin
                m_state = 1;
                m_limit = longint'(limit_i);
            end
        end else if (m_state == 1 && start_i) begin
            m_cyc = sat1(m_cyc);
            if (stall_i && !branch_i) m_stl = sat1(m_stl);
            if (flush_i)  m_fl  = sat1(m_fl);
            if (retire_i) m_ret = sat1(m_ret);
            m_pc = longint'(pc_i);
            if (m_limit != 0 && m_cyc == m_limit) begin
                m_state = 2;
                m_hit   = 1;
            end
        end
        m_halt = (m_state == 2);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", 64'(state_o), 64'(m_state));
        chk("halt", 64'(halt_o), 64'(m_halt));
        chk("ack", 64'(rd_ack_o), 64'(m_ack));
        chk("data", 64'(rd_data_o), 64'(m_data));
    endtask

    task automatic rd(input int sel, input logic [63:0] exp, input string tag);
        if (m_ack) tick();
        rd_req_i = 1'b1;
        rd_sel_i = 3'(sel);
        tick();
        rd_req_i = 1'b0;
        chk(tag, 64'(rd_data_o), exp);
        $display("[TB] read sel=%0d data=%0h (%s)", sel, rd_data_o, tag);
    endtask

    task automatic clear_tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_halt", 64'(halt_o), 64'd0);
        chk("rst_ack", 64'(rd_ack_o), 64'd0);
        chk("rst_data", 64'(rd_data_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b1;

        // Cycle limit of 64 with a retirement every cycle.
        limit_i = 32'd64; start_i = 1'b1; retire_i = 1'b1;
        tick();
        repeat (64) tick();
        chk("limit_state", 64'(state_o), 64'd2);
        chk("limit_halt", 64'(halt_o), 64'd1);
        repeat (10) tick();
        rd(0, 64'd64, "limit_cycle");
        rd(3, 64'd64, "limit_retire");

        // Clear with start high lands in IDLE, then stall/branch/flush pattern.
        retire_i = 1'b0; limit_i = '0;
        clear_tick();
        chk("clear_idle", 64'(state_o), 64'd0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            stall_i  = 1'b1;
            branch_i = (c == 2 || c == 3);
            flush_i  = (c == 3);
            tick();
        end
        stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0; start_i = 1'b0;
        rd(1, 64'd3, "stall_cnt");
        rd(2, 64'd1, "flush_cnt");

        // Pause for 7 cycles inside a 20-cycle run.
        clear_tick();
        start_i = 1'b1;
        tick();
        repeat (10) tick();
        start_i = 1'b0;
        repeat (7) tick();
        chk("pause_state", 64'(state_o), 64'd1);
        start_i = 1'b1;
        repeat (10) tick();
        start_i = 1'b0;
        rd(0, 64'd20, "pause_cycle");
        clear_tick();
        for (int s = 0; s < 8; s++) rd(s, 64'd0, "clear_read");

        // Asynchronous reset in the middle of a run.
        start_i = 1'b1;
        tick();
        repeat (10) tick();
        rd_req_i = 1'b1; rd_sel_i = 3'd0;
        tick();
        rd_req_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("arst_state", 64'(state_o), 64'd0);
        chk("arst_halt", 64'(halt_o), 64'd0);
        chk("arst_ack", 64'(rd_ack_o), 64'd0);
        chk("arst_data", 64'(rd_data_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_i = 1'b1;
        limit_i = 32'd5;
        tick();
        repeat (5) tick();
        chk("relatch_state", 64'(state_o), 64'd2);
        rd(0, 64'd5, "relatch_cycle");

        // Held request gives an ack every other cycle with pre-edge data.
        limit_i = '0;
        clear_tick();
        tick();
        repeat (5) tick();
        rd_req_i = 1'b1; rd_sel_i = 3'd0;
        tick();
        chk("hold_d1", 64'(rd_data_o), 64'd5);
        tick();
        chk("hold_gap", 64'(rd_ack_o), 64'd0);
        tick();
        chk("hold_d2", 64'(rd_data_o), 64'd7);
        tick();
        rd_req_i = 1'b0;
        pc_i = 32'h40;
        tick();
        start_i = 1'b0;
        rd(4, 64'h40, "last_pc");

        // Randomized traffic against the model.
        clear_tick();
        for (int i = 0; i < 400; i++) begin
            start_i  = ($urandom_range(0, 3) != 0);
            stall_i  = 1'($urandom);
            branch_i = 1'($urandom);
            flush_i  = 1'($urandom);
            retire_i = 1'($urandom);
            pc_i     = $urandom;
            rd_req_i = 1'($urandom);
            rd_sel_i = 3'($urandom_range(0, 7));
            clear_i  = ($urandom_range(0, 39) == 0);
            if (clear_i || i == 0)
                limit_i = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(10, 60));
            tick();
        end
        clear_i = 1'b0; rd_req_i = 1'b0; start_i = 1'b0; stall_i = 1'b0;
        $display("[TB] random phase done: cyc=%0d stall=%0d flush=%0d retire=%0d", m_cyc, m_stl, m_fl, m_ret);

        // Narrow counters saturate rather than wrap.
        s4_start = 1'b1;
        tick();
        s4_stall = 1'b1;
        repeat (20) tick();
        s4_start = 1'b0; s4_stall = 1'b0;
        chk("sat_state", 64'(s4_state), 64'd1);
        chk("sat_halt", 64'(s4_halt), 64'd0);
        s4_rd_req = 1'b1; s4_rd_sel = 3'd0;
        tick();
        s4_rd_req = 1'b0;
        chk("sat_cycle", 64'(s4_data), 64'd15);
        tick();
        s4_rd_req = 1'b1; s4_rd_sel = 3'd1;
        tick();
        s4_rd_req = 1'b0;
        chk("sat_stall", 64'(s4_data), 64'd15);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
